// File: rtl/stream_pool_layer.sv
// stream_pool_layer: streaming non-overlapping POOL_SIZE x POOL_SIZE pooling
// (max or average) over a raster-ordered multi-channel image, with
// valid/ready handshakes on the input and output sides.
// Optional feature macro: STREAM_POOL_FUSED_RELU_EN. When defined, negative
// samples are clamped to zero before they reach the accumulators.
module stream_pool_layer #(
  parameter int unsigned I_WIDTH    = 16,
  parameter int unsigned CHANNELS   = 5,
  parameter int unsigned IMAGE_SIZE = 254,
  parameter int unsigned POOL_SIZE  = 2,
  parameter int unsigned MODE       = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [I_WIDTH*CHANNELS-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [I_WIDTH*CHANNELS-1:0] out_data,
  output logic                        out_last
);

  localparam int unsigned DATA_W   = I_WIDTH * CHANNELS;
  localparam int unsigned OUT_SIZE = IMAGE_SIZE / POOL_SIZE;
  localparam int unsigned LOG2P    = $clog2(POOL_SIZE);
  localparam int unsigned SHIFT    = (MODE == 1) ? 2 * LOG2P : 0;
  localparam int unsigned ACC_W    = I_WIDTH + SHIFT;
  localparam int unsigned CNT_W    = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int unsigned PH_W     = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int unsigned IDX_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  // Reject configurations the datapath cannot represent.
  generate
    if (MODE > 1) begin : g_bad_mode
      $error("stream_pool_layer: MODE must be 0 (max) or 1 (average)");
    end
    if (MODE == 1 && (32'd1 << LOG2P) != POOL_SIZE) begin : g_bad_avg_pool
      $error("stream_pool_layer: average mode needs a power-of-two POOL_SIZE");
    end
    if (OUT_SIZE == 0) begin : g_bad_size
      $error("stream_pool_layer: POOL_SIZE must not exceed IMAGE_SIZE");
    end
  endgenerate

  // Raster position: full coordinates for frame wrap, phase within the
  // window and window index so no divider is needed.
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col_blk;
  logic [CNT_W-1:0] r_row_blk;
  logic [PH_W-1:0]  r_col_ph;
  logic [PH_W-1:0]  r_row_ph;

  // Partial-window accumulators, one row of windows deep.
  logic signed [ACC_W-1:0] r_acc [OUT_SIZE][CHANNELS];

  // Registered output stage.
  logic              r_out_valid;
  logic              r_out_last;
  logic [DATA_W-1:0] r_out_data;

  logic              w_accept;
  logic              w_in_win;
  logic              w_first;
  logic              w_col_end;
  logic              w_row_end;
  logic              w_col_ph_end;
  logic              w_row_ph_end;
  logic              w_complete;
  logic              w_last;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_result;

  logic signed [I_WIDTH-1:0] w_samp [CHANNELS];
  logic signed [ACC_W-1:0]   w_ext  [CHANNELS];
  logic signed [ACC_W-1:0]   w_cur  [CHANNELS];
  logic signed [ACC_W-1:0]   w_new  [CHANNELS];

  assign in_ready  = !r_out_valid | out_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;

  assign w_accept     = in_valid & in_ready;
  assign w_in_win     = ({1'b0, r_col_blk} < (CNT_W + 1)'(OUT_SIZE)) &&
                        ({1'b0, r_row_blk} < (CNT_W + 1)'(OUT_SIZE));
  assign w_first      = (r_col_ph == '0) && (r_row_ph == '0);
  assign w_col_end    = (r_col == CNT_W'(IMAGE_SIZE - 1));
  assign w_row_end    = (r_row == CNT_W'(IMAGE_SIZE - 1));
  assign w_col_ph_end = (r_col_ph == PH_W'(POOL_SIZE - 1));
  assign w_row_ph_end = (r_row_ph == PH_W'(POOL_SIZE - 1));
  assign w_complete   = w_in_win & w_col_ph_end & w_row_ph_end;
  assign w_last       = (r_col_blk == CNT_W'(OUT_SIZE - 1)) &&
                        (r_row_blk == CNT_W'(OUT_SIZE - 1));
  assign w_idx        = IDX_W'(r_col_blk);

  // Per-channel read-modify-write value and the pooled result of a window.
  always_comb begin
    w_result = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_samp[c] = in_data[c*I_WIDTH +: I_WIDTH];
`ifdef STREAM_POOL_FUSED_RELU_EN
      if (w_samp[c][I_WIDTH-1]) begin
        w_samp[c] = '0;
      end
`endif
      w_ext[c] = ACC_W'(w_samp[c]);
      w_cur[c] = r_acc[w_idx][c];
      if (w_first) begin
        w_new[c] = w_ext[c];
      end else if (MODE == 0) begin
        w_new[c] = (w_ext[c] > w_cur[c]) ? w_ext[c] : w_cur[c];
      end else begin
        w_new[c] = w_cur[c] + w_ext[c];
      end
      w_result[c*I_WIDTH +: I_WIDTH] = I_WIDTH'(w_new[c] >>> SHIFT);
    end
  end

  // Accumulator update for accepted in-window beats; stale entries are
  // overwritten by the first pixel of the next window, so no reset is needed.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept && w_in_win) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[w_idx][c] <= w_new[c];
      end
    end
  end

  // Raster position tracking with column, row and frame wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_col_blk <= '0;
      r_row_blk <= '0;
      r_col_ph  <= '0;
      r_row_ph  <= '0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col     <= '0;
        r_col_ph  <= '0;
        r_col_blk <= '0;
        if (w_row_end) begin
          r_row     <= '0;
          r_row_ph  <= '0;
          r_row_blk <= '0;
        end else begin
          r_row <= r_row + CNT_W'(1);
          if (w_row_ph_end) begin
            r_row_ph  <= '0;
            r_row_blk <= r_row_blk + CNT_W'(1);
          end else begin
            r_row_ph <= r_row_ph + PH_W'(1);
          end
        end
      end else begin
        r_col <= r_col + CNT_W'(1);
        if (w_col_ph_end) begin
          r_col_ph  <= '0;
          r_col_blk <= r_col_blk + CNT_W'(1);
        end else begin
          r_col_ph <= r_col_ph + PH_W'(1);
        end
      end
    end
  end

  // Output register: load on window completion, clear once consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept && w_complete) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_last;
      r_out_data  <= w_result;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

endmodule
